fft_bitrev_buf: RTL



---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_bitrev_ram.sv | 35 +++
 rtl/fft_bitrev_buf.sv | 95 +++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder buffer: frame size,
// complex word type and index bit reversal.
package fft_pkg;

  localparam int FFT_DBW = 4;
  localparam int FFT_CBW = 3;
  localparam int FFT_N   = 1 << FFT_CBW;

  // Imaginary part in the upper half, real part in the lower half.
  typedef logic [2*FFT_DBW-1:0] cplx_t;

  function automatic int fft_n(input int cbw);
    return 1 << cbw;
  endfunction

  // Reverses the low w bits of a (w <= 16); upper result bits are zero.
  function automatic logic [15:0] bitrev(input logic [15:0] a, input int unsigned w);
    logic [15:0] r;
    r = {<<{a}};
    return r >> (16 - w);
  endfunction

endpackage

// File: rtl/fft_bitrev_ram.sv
// Two-bank register store for the reorder buffer: one write port and one
// registered read port whose output is forced to zero when not enabled.
module fft_bitrev_ram #(
  parameter int DBW = 4,
  parameter int CBW = 3
) (
  input  logic               clk,
  input  logic               rstx,
  input  logic               i_wbank,
  input  logic [CBW-1:0]     i_waddr,
  input  logic [2*DBW-1:0]   i_wdata,
  input  logic               i_rd_en,
  input  logic               i_rbank,
  input  logic [CBW-1:0]     i_raddr,
  output logic [2*DBW-1:0]   o_rdata
);

  localparam int DEPTH = 2 << CBW;

  logic [2*DBW-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    r_mem[{i_wbank, i_waddr}] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      o_rdata <= '0;
    end else begin
      o_rdata <= i_rd_en ? r_mem[{i_rbank, i_raddr}] : '0;
    end
  end

endmodule

// File: rtl/fft_bitrev_buf.sv
// Reorders bit-reversed FFT output frames into natural order via ping-pong banks.
// Optional frame_start output enabled by defining FFT_BITREV_FSTART_EN.
module fft_bitrev_buf
  import fft_pkg::*;
#(
  parameter int DBW = FFT_DBW,
  parameter int CBW = FFT_CBW,
  parameter int LAT = 0
) (
  input  logic               clk,
  input  logic               rstx,
  input  logic               clear,
  input  logic [2*DBW-1:0]   din,
  output logic [2*DBW-1:0]   dout,
  output logic               dout_valid
`ifdef FFT_BITREV_FSTART_EN
  ,
  output logic               frame_start
`endif
);

  localparam int N = fft_n(CBW);
  // Counter preload so that index 0 lands on wcnt==0 after LAT cycles.
  localparam logic [CBW-1:0] WCNT_CLR = CBW'((N - LAT) % N);

  logic [CBW-1:0] r_wcnt;
  logic           r_wbank;
  logic           r_filled;
  logic           r_prefix;
  logic           r_dout_valid;
  logic           w_wrap;
  logic           w_rd_en;
  logic [CBW-1:0] w_waddr;

  assign w_wrap  = (r_wcnt == CBW'(N - 1));
  assign w_waddr = CBW'(bitrev(16'(r_wcnt), CBW));
  assign w_rd_en = r_filled && !clear;

  // r_prefix marks the LAT garbage words so their wrap does not count as a frame.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      r_wcnt       <= '0;
      r_wbank      <= 1'b0;
      r_filled     <= 1'b0;
      r_prefix     <= 1'b0;
      r_dout_valid <= 1'b0;
    end else if (clear) begin
      r_wcnt       <= WCNT_CLR;
      r_wbank      <= 1'b0;
      r_filled     <= 1'b0;
      r_prefix     <= (LAT != 0);
      r_dout_valid <= 1'b0;
    end else begin
      r_wcnt       <= r_wcnt + CBW'(1);
      r_dout_valid <= r_filled;
      if (w_wrap) begin
        r_wbank <= ~r_wbank;
        if (r_prefix) r_prefix <= 1'b0;
        else          r_filled <= 1'b1;
      end
    end
  end

  fft_bitrev_ram #(
    .DBW(DBW),
    .CBW(CBW)
  ) u_ram (
    .clk     (clk),
    .rstx    (rstx),
    .i_wbank (r_wbank),
    .i_waddr (w_waddr),
    .i_wdata (din),
    .i_rd_en (w_rd_en),
    .i_rbank (~r_wbank),
    .i_raddr (r_wcnt),
    .o_rdata (dout)
  );

  assign dout_valid = r_dout_valid;

`ifdef FFT_BITREV_FSTART_EN
  logic r_fstart;

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      r_fstart <= 1'b0;
    end else begin
      r_fstart <= w_rd_en && (r_wcnt == '0);
    end
  end

  assign frame_start = r_fstart;
`endif

endmodule
